// File: rtl/shift_seq_pkg.sv
// Shared types and sizing helpers for the multi-pass shift sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Largest shift one pass of the narrow shifter can apply.
  function automatic int max_step(input int step_width);
    return (1 << step_width) - 1;
  endfunction

  function automatic int CeilLog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Combinational left barrel shifter (zero fill), one log2 stage per shift bit.
module leftBarrelShifter #(
  parameter int DATA_WIDTH  = 22,
  parameter int SHIFT_WIDTH = 2
) (
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic [SHIFT_WIDTH-1:0] shift_i,
  output logic [DATA_WIDTH-1:0]  data_o
);

  logic [DATA_WIDTH-1:0] stage;

  always_comb begin
    stage = data_i;
    for (int s = 0; s < SHIFT_WIDTH; s++) begin
      if (shift_i[s]) stage = stage << (1 << s);
    end
    data_o = stage;
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-pass arithmetic left shift built from a narrow barrel shifter.
// Define SHIFT_SEQ_OVF_DETECT_EN to generate signed-overflow detection on ovf_o.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 22,
  parameter int SHIFT_WIDTH = 5,
  parameter int STEP_WIDTH  = 2
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic [SHIFT_WIDTH-1:0] shift_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   ovf_o,
  output logic                   busy_o
);

  localparam int MAX_STEP = max_step(STEP_WIDTH);
  localparam int CNT_LOG  = CeilLog2(DATA_WIDTH + 1);
  localparam int REM_W    = (SHIFT_WIDTH > CNT_LOG) ? SHIFT_WIDTH : CNT_LOG;

  state_e                state_q, state_d;
  logic [REM_W-1:0]      rem_q, rem_d, rem_next, shift_clamped;
  logic [DATA_WIDTH-1:0] work_q, work_d, shifted;
  logic [STEP_WIDTH-1:0] chunk;

  // Shifts of DATA_WIDTH or more all give zero, so clamping is exact.
  always_comb begin
    if (int'(shift_i) >= DATA_WIDTH) shift_clamped = REM_W'(DATA_WIDTH);
    else                             shift_clamped = REM_W'(shift_i);
  end

  always_comb begin
    if (int'(rem_q) > MAX_STEP) chunk = STEP_WIDTH'(MAX_STEP);
    else                        chunk = STEP_WIDTH'(rem_q);
  end

  assign rem_next = rem_q - REM_W'(chunk);

  leftBarrelShifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHIFT_WIDTH(STEP_WIDTH)
  ) u_shifter (
    .data_i (work_q),
    .shift_i(chunk),
    .data_o (shifted)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    work_d  = work_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          work_d  = data_i;
          rem_d   = shift_clamped;
          state_d = (shift_clamped == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_d = shifted;
        rem_d  = rem_next;
        if (rem_next == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      work_q  <= work_d;
    end
  end

`ifdef SHIFT_SEQ_OVF_DETECT_EN
  logic ovf_q, ovf_d, sign_q, sign_d, pass_ovf;

  // A pass overflows if any bit leaving the top, or the new MSB, disagrees with the original sign.
  always_comb begin
    pass_ovf = (shifted[DATA_WIDTH-1] != sign_q);
    for (int i = 0; i < MAX_STEP; i++) begin
      if ((i < int'(chunk)) && (work_q[DATA_WIDTH-1-i] != sign_q)) pass_ovf = 1'b1;
    end
  end

  always_comb begin
    ovf_d  = ovf_q;
    sign_d = sign_q;
    if ((state_q == ST_IDLE) && in_valid_i) begin
      ovf_d  = 1'b0;
      sign_d = data_i[DATA_WIDTH-1];
    end else if (state_q == ST_SHIFT) begin
      ovf_d = ovf_q | pass_ovf;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ovf_q  <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      sign_q <= sign_d;
    end
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE);
  assign data_o      = work_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a pass-count reference model checked every cycle.
module tb_shift_sequencer;

  localparam int DW   = 22;
  localparam int SW   = 5;
  localparam int STW  = 2;
  localparam int MAXS = 3;
`ifdef SHIFT_SEQ_OVF_DETECT_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          out_ready_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [SW-1:0] shift_i = '0;
  logic          in_ready_o, out_valid_o, ovf_o, busy_o;
  logic [DW-1:0] data_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_sequencer #(
    .DATA_WIDTH (DW),
    .SHIFT_WIDTH(SW),
    .STEP_WIDTH (STW)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .data_i     (data_i),
    .shift_i    (shift_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .data_o     (data_o),
    .ovf_o      (ovf_o),
    .busy_o     (busy_o)
  );

  // Reference: result is data*2^s truncated, P = ceil(min(s,DW)/MAXS) cycles in flight.
  function automatic int clampsh(input logic [SW-1:0] s);
    return (int'(s) >= DW) ? DW : int'(s);
  endfunction

  function automatic int passes(input logic [SW-1:0] s);
    return (clampsh(s) + MAXS - 1) / MAXS;
  endfunction

  function automatic logic [DW-1:0] ref_res(input logic [DW-1:0] d, input logic [SW-1:0] s);
    logic [63:0] w;
    w = 64'(d) << clampsh(s);
    return w[DW-1:0];
  endfunction

  function automatic logic ref_ovf(input logic [DW-1:0] d, input logic [SW-1:0] s);
    longint v;
    longint lim;
    v   = longint'($signed(d));
    v   = v <<< clampsh(s);
    lim = 64'sd1 <<< (DW - 1);
    return OVF_EN && ((v >= lim) || (v < -lim));
  endfunction

  int            m_phase = 0;  // 0 idle, 1 shifting, 2 result pending
  int            m_left  = 0;
  logic [DW-1:0] m_res   = '0;
  logic          m_ovf   = 1'b0;
  logic [DW-1:0] m_last  = '0;

  always @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      m_phase <= 0;
      m_left  <= 0;
      m_res   <= '0;
      m_ovf   <= 1'b0;
      m_last  <= '0;
    end else begin
      case (m_phase)
        0: if (in_valid_i) begin
          m_res   <= ref_res(data_i, shift_i);
          m_ovf   <= ref_ovf(data_i, shift_i);
          m_left  <= passes(shift_i);
          m_phase <= (passes(shift_i) == 0) ? 2 : 1;
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) m_phase <= 2;
        end
        default: if (out_ready_i) begin
          m_last  <= m_res;
          m_phase <= 0;
        end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic cycle_check();
    chk("in_ready", 64'(in_ready_o), 64'(m_phase == 0));
    chk("out_valid", 64'(out_valid_o), 64'(m_phase == 2));
    chk("busy", 64'(busy_o), 64'(m_phase != 0));
    if (m_phase == 2) begin
      chk("model_data", 64'(data_o), 64'(m_res));
      chk("model_ovf", 64'(ovf_o), 64'(m_ovf));
    end else if (m_phase == 0) begin
      chk("idle_data", 64'(data_o), 64'(m_last));
    end
  endtask

  task automatic run_req(input logic [DW-1:0] d, input logic [SW-1:0] s,
                         input logic [DW-1:0] exp_data, input logic exp_ovf,
                         input int exp_lat, input int hold);
    int n;
    @(posedge clk); #1;
    out_ready_i = (hold == 0);
    in_valid_i  = 1'b1;
    data_i      = d;
    shift_i     = s;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    data_i     = 22'h15A5A5;
    shift_i    = 5'd1;
    n = 0;
    @(negedge clk);
    while (!out_valid_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(exp_lat));
    chk("lit_data", 64'(data_o), 64'(exp_data));
    chk("lit_ovf", 64'(ovf_o), 64'(exp_ovf));
    for (int i = 0; i < hold; i++) begin
      in_valid_i = ~in_valid_i;
      data_i     = DW'($urandom);
      shift_i    = 5'd0;
      @(negedge clk);
      chk("hold_data", 64'(data_o), 64'(exp_data));
      chk("hold_ovf", 64'(ovf_o), 64'(exp_ovf));
      chk("hold_in_ready", 64'(in_ready_o), 64'd0);
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk);
    chk("in_ready_after", 64'(in_ready_o), 64'd1);
    chk("out_valid_after", 64'(out_valid_o), 64'd0);
    out_ready_i = 1'b0;
  endtask

  initial begin
    fork
      begin
        forever begin
          @(negedge clk);
          cycle_check();
        end
      end
      begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        rstn_i = 1'b1;

        run_req(22'd1,       5'd7,  22'd128,     1'b0,   3, 0);
        run_req(22'h2ABCDE,  5'd0,  22'h2ABCDE,  1'b0,   0, 0);
        run_req(22'h000005,  5'd30, 22'd0,       OVF_EN, 8, 0);
        run_req(22'h100000,  5'd1,  22'h200000,  OVF_EN, 1, 0);
        run_req(22'h3FFFFF,  5'd4,  22'h3FFFF0,  1'b0,   2, 0);
        run_req(22'h000123,  5'd5,  22'h002460,  1'b0,   2, 6);
        run_req(22'h000007,  5'd3,  22'h000038,  1'b0,   1, 0);
        run_req(22'h3FFFFF,  5'd22, 22'd0,       OVF_EN, 8, 0);
        run_req(22'h000000,  5'd31, 22'd0,       1'b0,   8, 0);

        // Abort a 9-bit shift during its second pass.
        @(posedge clk); #1;
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        data_i      = 22'd5;
        shift_i     = 5'd9;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        @(posedge clk); #2;
        rstn_i = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready_o), 64'd1);
        chk("midrst_out_valid", 64'(out_valid_o), 64'd0);
        chk("midrst_data", 64'(data_o), 64'd0);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        @(negedge clk);
        rstn_i = 1'b1;
        run_req(22'd3, 5'd2, 22'd12, 1'b0, 1, 0);
        repeat (2) @(negedge clk);
      end
      begin
        repeat (5000) @(posedge clk);
        tests++;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
      end
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
